// File: rtl/reg_arb_pkg.sv
// reg_arb_pkg: shared defaults and arbiter state encoding for reg_write_arbiter
package reg_arb_pkg;
   localparam int DEF_WIDTH = 16;
   localparam int DEF_AW    = 2;
   localparam int DEF_DEPTH = 1 << DEF_AW;
   localparam logic LAST_A = 1'b0;
   localparam logic LAST_B = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational 2-way round-robin arbiter (bit 0 = A, bit 1 = B)
module rr_arb2
   import reg_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] grant,
   output logic       next_last
);
   always_comb begin
      grant[0]  = req[0] & (~req[1] | (last == LAST_B));
      grant[1]  = req[1] & (~req[0] | (last == LAST_A));
      next_last = grant[1] ? LAST_B : grant[0] ? LAST_A : last;
   end
endmodule

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: register bank shared by two round-robin write ports and one
// registered read port with per-entry written flags
module reg_write_arbiter
   import reg_arb_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = DEF_AW
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             reqa,
   input  logic [AW-1:0]    addra,
   input  logic [WIDTH-1:0] dina,
   output logic             gnta,
   input  logic             reqb,
   input  logic [AW-1:0]    addrb,
   input  logic [WIDTH-1:0] dinb,
   output logic             gntb,
   input  logic             rd,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] dout,
   output logic             rvalid,
   output logic             rerr,
   output logic             last
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [DEPTH-1:0] written;
   logic [1:0]       grant;
   logic             next_last;

   rr_arb2 u_arb (
      .req       ({reqb, reqa}),
      .last      (last),
      .grant     (grant),
      .next_last (next_last)
   );

   // Read samples pre-write contents, so a same-edge commit is seen one read later.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         written <= '0;
         gnta    <= 1'b0;
         gntb    <= 1'b0;
         rvalid  <= 1'b0;
         rerr    <= 1'b0;
         dout    <= '0;
         last    <= LAST_B;
      end else begin
         gnta   <= grant[0];
         gntb   <= grant[1];
         last   <= next_last;
         rvalid <= rd;
         rerr   <= rd & ~written[raddr];
         if (rd) dout <= mem[raddr];
         if (grant[0]) begin
            mem[addra]     <= dina;
            written[addra] <= 1'b1;
         end else if (grant[1]) begin
            mem[addrb]     <= dinb;
            written[addrb] <= 1'b1;
         end
      end
   end
endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Shares a small 16-bit register bank between two independent write requesters (port A, port B) and one reader.
- Round-robin arbitration: at most one write commits per cycle. On a conflict, the requester not granted last time wins.
- Registered read with per-entry written flags.
- Sits in front of the processor's storage register; replaces ad-hoc dual-write priority logic with an explicit req/gnt handshake.

Parameters:
- WIDTH, 16, data width of each entry.
- DEPTH, 4, number of entries.
- AW, 2, address width; must equal clog2(DEPTH).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- reqa  in  1  port A write request; held until gnta.
- addra  in  AW  port A write address.
- dina  in  WIDTH  port A write data.
- gnta  out  1  one-cycle pulse: port A write committed this edge.
- reqb  in  1  port B write request.
- addrb  in  AW  port B write address.
- dinb  in  WIDTH  port B write data.
- gntb  out  1  one-cycle pulse: port B write committed.
- rd  in  1  read request.
- raddr  in  AW  read address.
- dout  out  WIDTH  read data, valid when rvalid.
- rvalid  out  1  pulse one cycle after rd.
- rerr  out  1  with rvalid: entry never written since reset.
- last  out  1  last granted port (0 = A, 1 = B).

Behaviour:
- Reset (sync, on clk edge with reset=1):
  - All entries cleared to 0; written flags cleared.
  - gnta, gntb, rvalid, rerr = 0; dout = 0.
  - last = 1, so A wins the first conflict.
- Reset has priority over any request in the same cycle; no write commits, no read returns.
- Arbiter state is the single flop `last`. Two states: LAST_A, LAST_B.
  - Only reqa -> commit A, next LAST_A.
  - Only reqb -> commit B, next LAST_B.
  - Both, in LAST_B -> commit A, next LAST_A. B waits.
  - Both, in LAST_A -> commit B, next LAST_B. A waits.
  - Neither -> hold state.
- Handshake:
  - Grant is combinational from req and last, registered into gnta/gntb. gnt is asserted in the cycle after the edge that wrote the entry.
  - A requester must keep req, addr and din stable until it sees gnt, then may drop or change them the same cycle.
  - A request still high in the cycle gnt is seen is treated as a new request.
  - Max wait for a continuously requesting port is 1 cycle; no starvation.
- Commit: entry[addr] <= din; written[addr] <= 1. Same-address conflicts need no special case, since only one write commits per cycle.
- Read:
  - rd sampled at edge N; at edge N+1: dout = entry[raddr] as of edge N (pre-write value), rvalid = 1, rerr = ~written[raddr].
  - Read of an address committed at the same edge returns the old value. The new value is visible to a read issued one cycle later.
  - With rd=0: rvalid = 0 and rerr = 0; dout holds its last value.
  - Back-to-back reads give one result per cycle.
- raddr, addra and addrb are always in range when DEPTH = 2^AW. Non-power-of-2 DEPTH is unsupported.

Decomposition:
- Shared package reg_arb_pkg:
  - WIDTH/AW defaults.
  - Localparams LAST_A=1'b0, LAST_B=1'b1.
- One natural sub-module: rr_arb2 (2-way round-robin, inputs req[1:0] and last, outputs one-hot grant and next_last), combinational.
- Storage and read register stay in the top module.

Test Plan:
- Reset then read addr 0..3 -> rvalid=1, dout=0, rerr=1 on each; last=1.
- reqa=1, addra=1, dina=16'h0001 for one cycle -> gnta pulses next cycle; read addr 1 -> dout=16'h0001, rerr=0; last=0.
- reqa and reqb both held, addra=2/dina=16'h269A, addrb=3/dinb=16'h6FA7, last=0 -> B granted first, A one cycle later. Reads give entry2=16'h269A, entry3=16'h6FA7.
- Both ports continuously requesting the same address 0 for 6 cycles with changing data -> grants alternate A,B,A,B…; final entry0 = data of the last granted port.
- rd, raddr=1 in the same cycle as reqb commit to addr 1 with 16'hBEEF (old 16'h0001) -> returns 16'h0001; rd the next cycle -> 16'hBEEF.
- reset asserted the same cycle as reqa and rd -> no gnta, rvalid=0, all entries 0, written flags clear.
